// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the five-stage RISC-V core.
//
// Owns the program counter and drives the synchronous-read BIOS and IMEM
// instruction ports from the combinational next PC, so the instruction for
// id_pc is available at decode in the same cycle id_pc is. Applies execute
// flushes, decode stalls and decode redirects, and keeps fetch perf counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_stall            decode hazard stall, hold the PC
//   ex_flush/ex_target  execute mispredict redirect
//   id_target_taken/id_target  decode-predicted redirect
//   perf_clr            synchronous clear of all perf counters
//   id_pc               PC of the instruction at decode
//   bios_addr/bios_en   BIOS read port (word address)
//   imem_addr/imem_en   IMEM read port (word address)
//   perf_*              cycle, fetch, flush and predicted-redirect counters
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_stall,
  input  logic               ex_flush,
  input  logic [31:0]        ex_target,
  input  logic               id_target_taken,
  input  logic [31:0]        id_target,
  input  logic               perf_clr,
  output logic [31:0]        id_pc,
  output logic [BIOS_AW-1:0] bios_addr,
  output logic               bios_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushes,
  output logic [31:0]        perf_pred_redirs
);

  logic [31:0] r_pc_q;
  logic [31:0] w_next_pc;
  logic [3:0]  w_region;
  logic        w_advance;

  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushes;
  logic [31:0] r_perf_pred_redirs;

  // A flush beats a stall (the stalled instruction is squashed) and a stall
  // beats a decode redirect (decode re-asserts it once the stall clears).
  always_comb begin
    w_next_pc = r_pc_q + 32'd4;
    if (rst) begin
      w_next_pc = RESET_PC;
    end else if (ex_flush) begin
      w_next_pc = {ex_target[31:2], 2'b00};
    end else if (id_stall) begin
      w_next_pc = r_pc_q;
    end else if (id_target_taken) begin
      w_next_pc = {id_target[31:2], 2'b00};
    end
  end

  // Addresses come from next_pc because both memories register the address;
  // during a stall next_pc is pc_q, so the read data keeps matching id_pc.
  assign w_region  = w_next_pc[31:28];
  assign bios_addr = w_next_pc[BIOS_AW+1:2];
  assign imem_addr = w_next_pc[IMEM_AW+1:2];
  assign bios_en   = (w_region == 4'b0100);
  assign imem_en   = (w_region == 4'b0001);

  always_ff @(posedge clk) begin
    r_pc_q <= w_next_pc;
  end

  // The instruction at decode moves on to execute only when not stalled and
  // not squashed.
  assign w_advance = !ex_flush && !id_stall;

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      r_perf_cycles      <= '0;
      r_perf_fetched     <= '0;
      r_perf_flushes     <= '0;
      r_perf_pred_redirs <= '0;
    end else begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_advance) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (ex_flush) begin
        r_perf_flushes <= r_perf_flushes + 32'd1;
      end
      if (w_advance && id_target_taken) begin
        r_perf_pred_redirs <= r_perf_pred_redirs + 32'd1;
      end
    end
  end

  assign id_pc            = r_pc_q;
  assign perf_cycles      = r_perf_cycles;
  assign perf_fetched     = r_perf_fetched;
  assign perf_flushes     = r_perf_flushes;
  assign perf_pred_redirs = r_perf_pred_redirs;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed-vector bench for if_stage with hand-computed
// expectations. Inputs change 1 time unit after a rising edge; combinational
// outputs are sampled 1 unit later, registered outputs after the next edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        ex_flush;
  logic [31:0] ex_target;
  logic        id_target_taken;
  logic [31:0] id_target;
  logic        perf_clr;
  logic [31:0] id_pc;
  logic [11:0] bios_addr;
  logic        bios_en;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] perf_cycles;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
  logic [31:0] perf_pred_redirs;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .id_stall         (id_stall),
    .ex_flush         (ex_flush),
    .ex_target        (ex_target),
    .id_target_taken  (id_target_taken),
    .id_target        (id_target),
    .perf_clr         (perf_clr),
    .id_pc            (id_pc),
    .bios_addr        (bios_addr),
    .bios_en          (bios_en),
    .imem_addr        (imem_addr),
    .imem_en          (imem_en),
    .perf_cycles      (perf_cycles),
    .perf_fetched     (perf_fetched),
    .perf_flushes     (perf_flushes),
    .perf_pred_redirs (perf_pred_redirs)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_stall = 1'b0; ex_flush = 1'b0; ex_target = '0;
    id_target_taken = 1'b0; id_target = '0; perf_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    checks++; if (bios_addr !== 12'h000) begin errors++; $display("FAIL rst_bios_addr got %h exp 000", bios_addr); end
    checks++; if (bios_en !== 1'b1 || imem_en !== 1'b0) begin errors++; $display("FAIL rst_en got bios %b imem %b exp 1 0", bios_en, imem_en); end
    repeat (3) step();
    checks++; if (id_pc !== 32'h4000_0000) begin errors++; $display("FAIL rst_id_pc got %h exp 40000000", id_pc); end
    checks++; if (perf_cycles !== 0 || perf_fetched !== 0 || perf_flushes !== 0 || perf_pred_redirs !== 0) begin
      errors++; $display("FAIL rst_perf got %0d %0d %0d %0d exp 0 0 0 0", perf_cycles, perf_fetched, perf_flushes, perf_pred_redirs); end
    rst = 1'b0;
    #1;
    checks++; if (id_pc !== 32'h4000_0000 || bios_addr !== 12'h001) begin errors++; $display("FAIL rel0 got pc %h addr %h exp 40000000 001", id_pc, bios_addr); end
    step();
    checks++; if (id_pc !== 32'h4000_0004 || bios_addr !== 12'h002) begin errors++; $display("FAIL rel1 got pc %h addr %h exp 40000004 002", id_pc, bios_addr); end
    step();
    checks++; if (id_pc !== 32'h4000_0008 || perf_fetched !== 32'd2) begin errors++; $display("FAIL rel2 got pc %h fetched %0d exp 40000008 2", id_pc, perf_fetched); end
  endtask

  task automatic test_decode_redirect();
    id_target_taken = 1'b1; id_target = 32'h1000_0100;
    #1;
    checks++; if (imem_en !== 1'b1 || bios_en !== 1'b0 || imem_addr !== 14'h0040) begin
      errors++; $display("FAIL redir_mem got imem_en %b bios_en %b imem_addr %h exp 1 0 0040", imem_en, bios_en, imem_addr); end
    step();
    idle();
    checks++; if (id_pc !== 32'h1000_0100) begin errors++; $display("FAIL redir_pc got %h exp 10000100", id_pc); end
    checks++; if (perf_pred_redirs !== 32'd1 || perf_fetched !== 32'd3 || perf_cycles !== 32'd3) begin
      errors++; $display("FAIL redir_perf got pred %0d fetched %0d cycles %0d exp 1 3 3", perf_pred_redirs, perf_fetched, perf_cycles); end
  endtask

  task automatic test_misaligned();
    id_target_taken = 1'b1; id_target = 32'h1000_0103;
    step();
    idle();
    checks++; if (id_pc !== 32'h1000_0100) begin errors++; $display("FAIL misalign_pc got %h exp 10000100", id_pc); end
    checks++; if (perf_pred_redirs !== 32'd2) begin errors++; $display("FAIL misalign_pred got %0d exp 2", perf_pred_redirs); end
  endtask

  task automatic test_stall();
    id_target_taken = 1'b1; id_target = 32'h1000_0010;
    step();
    idle();
    checks++; if (id_pc !== 32'h1000_0010 || perf_fetched !== 32'd5) begin errors++; $display("FAIL stall_pre got pc %h fetched %0d exp 10000010 5", id_pc, perf_fetched); end
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_addr !== 14'h0004) begin errors++; $display("FAIL stall_addr%0d got %h exp 0004", i, imem_addr); end
      step();
      checks++; if (id_pc !== 32'h1000_0010 || perf_fetched !== 32'd5) begin
        errors++; $display("FAIL stall_hold%0d got pc %h fetched %0d exp 10000010 5", i, id_pc, perf_fetched); end
    end
    id_stall = 1'b0;
    #1;
    checks++; if (imem_addr !== 14'h0005) begin errors++; $display("FAIL stall_resume_addr got %h exp 0005", imem_addr); end
    step();
    checks++; if (id_pc !== 32'h1000_0014 || perf_fetched !== 32'd6 || perf_cycles !== 32'd9) begin
      errors++; $display("FAIL stall_resume got pc %h fetched %0d cycles %0d exp 10000014 6 9", id_pc, perf_fetched, perf_cycles); end
  endtask

  task automatic test_priority();
    ex_flush = 1'b1; ex_target = 32'h1000_0200;
    id_stall = 1'b1;
    id_target_taken = 1'b1; id_target = 32'h1000_0300;
    #1;
    checks++; if (imem_addr !== 14'h0080) begin errors++; $display("FAIL prio_addr got %h exp 0080", imem_addr); end
    step();
    idle();
    checks++; if (id_pc !== 32'h1000_0200) begin errors++; $display("FAIL prio_pc got %h exp 10000200", id_pc); end
    checks++; if (perf_flushes !== 32'd1 || perf_pred_redirs !== 32'd3 || perf_fetched !== 32'd6) begin
      errors++; $display("FAIL prio_perf got flush %0d pred %0d fetched %0d exp 1 3 6", perf_flushes, perf_pred_redirs, perf_fetched); end
    ex_flush = 1'b1; ex_target = 32'h1000_0207;
    step();
    idle();
    checks++; if (id_pc !== 32'h1000_0204 || perf_flushes !== 32'd2) begin
      errors++; $display("FAIL flush_misalign got pc %h flush %0d exp 10000204 2", id_pc, perf_flushes); end
  endtask

  task automatic test_other_region();
    id_target_taken = 1'b1; id_target = 32'h2000_0000;
    #1;
    checks++; if (bios_en !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL region_en got bios %b imem %b exp 0 0", bios_en, imem_en); end
    step();
    idle();
    checks++; if (id_pc !== 32'h2000_0000 || perf_pred_redirs !== 32'd4 || perf_fetched !== 32'd7 || perf_cycles !== 32'd12) begin
      errors++; $display("FAIL region_state got pc %h pred %0d fetched %0d cycles %0d exp 20000000 4 7 12", id_pc, perf_pred_redirs, perf_fetched, perf_cycles); end
  endtask

  task automatic test_clear_and_reset();
    perf_clr = 1'b1;
    id_target_taken = 1'b1; id_target = 32'h1000_0000;
    step();
    idle();
    checks++; if (perf_cycles !== 0 || perf_fetched !== 0 || perf_flushes !== 0 || perf_pred_redirs !== 0) begin
      errors++; $display("FAIL clr_perf got %0d %0d %0d %0d exp 0 0 0 0", perf_cycles, perf_fetched, perf_flushes, perf_pred_redirs); end
    checks++; if (id_pc !== 32'h1000_0000) begin errors++; $display("FAIL clr_pc got %h exp 10000000", id_pc); end
    step();
    checks++; if (perf_cycles !== 32'd1 || perf_fetched !== 32'd1) begin
      errors++; $display("FAIL clr_after got cycles %0d fetched %0d exp 1 1", perf_cycles, perf_fetched); end
    id_stall = 1'b1;
    step();
    rst = 1'b1;
    id_target_taken = 1'b1; id_target = 32'h1000_0400;
    #1;
    checks++; if (bios_en !== 1'b1 || bios_addr !== 12'h000) begin errors++; $display("FAIL midrst_mem got en %b addr %h exp 1 000", bios_en, bios_addr); end
    step();
    idle();
    checks++; if (id_pc !== 32'h4000_0000 || perf_cycles !== 32'd0) begin
      errors++; $display("FAIL midrst_pc got pc %h cycles %0d exp 40000000 0", id_pc, perf_cycles); end
    step();
    checks++; if (id_pc !== 32'h4000_0004 || perf_fetched !== 32'd1) begin
      errors++; $display("FAIL midrst_run got pc %h fetched %0d exp 40000004 1", id_pc, perf_fetched); end
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_decode_redirect();
    test_misaligned();
    test_stall();
    test_priority();
    test_other_region();
    test_clear_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
